mul_sched: RTL and testbench

Round-robin scheduler that shares the 64×64 signed Booth multiplier among NREQ requesters. It accepts one operand pair at a time with a valid/ready handshake, sequences the multiplier's start, wait and clear protocol, and returns the 128-bit product to the granted requester. A watchdog aborts the multiplier if completion never arrives. It sits between the requesting units and the single multiplier instance.

---
 rtl/mul_sched.sv | 160 ++++++++++++++++
 tb/tb_mul_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// mul_sched
//   Round-robin front end for a single shared 64x64 signed Booth multiplier.
//   One operand pair is accepted at a time over a valid/ready handshake. The
//   multiplier is then driven through start -> wait -> clear, and the 128-bit
//   product is returned to the requester that was granted. A watchdog aborts
//   the operation if the multiplier never signals completion.
//
// Parameters
//   NREQ     number of requesters (2..4)
//   TIMEOUT  maximum number of cycles spent in WAIT before aborting
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid[NREQ], req_ready[NREQ]  per-requester handshake (ready one-hot)
//   req_multiplier, req_multiplicand  64-bit operand slices, slice i = requester i
//   rsp_valid[NREQ]                   one-cycle one-hot response pulse
//   rsp_result[128], rsp_err          product / timeout flag, held until next response
//   busy                              high whenever the scheduler is not IDLE
//   op_count[32]                      successful completions, wraps
//   mul_op_start, mul_op_clear        multiplier control pulses
//   mul_multiplier, mul_multiplicand  operands presented to the multiplier
//   mul_op_done, mul_result           multiplier completion pulse and product
module mul_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_multiplier,
  input  logic [64*NREQ-1:0]   req_multiplicand,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [127:0]         rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [31:0]          op_count,
  output logic                 mul_op_start,
  output logic                 mul_op_clear,
  output logic [63:0]          mul_multiplier,
  output logic [63:0]          mul_multiplicand,
  input  logic                 mul_op_done,
  input  logic [127:0]         mul_result
);

  localparam int IDW = (NREQ > 2) ? 2 : 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [CW-1:0]   wait_cnt;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  next_ptr;
  logic [63:0]     sel_multiplier;
  logic [63:0]     sel_multiplicand;

  // Rotating priority search: start at rr_ptr, wrap, first valid wins.
  always_comb begin
    int              idx;
    logic [IDW-1:0]  idx_w;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!grant_found && req_valid[idx_w]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  // Grant is only offered while idle, so at most one transfer per operation.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) req_ready[grant_id] = 1'b1;
  end

  assign sel_multiplier   = req_multiplier[{grant_id, 6'b0} +: 64];
  assign sel_multiplicand = req_multiplicand[{grant_id, 6'b0} +: 64];
  assign next_ptr         = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  assign busy             = (state != S_IDLE);

  // Sequencer. Control and response outputs are pulses that default low each
  // cycle. The product is captured in WAIT because the clear that follows
  // also zeroes the multiplier's result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      gnt_id           <= '0;
      wait_cnt         <= '0;
      mul_op_start     <= 1'b0;
      mul_op_clear     <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      rsp_valid        <= '0;
      rsp_result       <= '0;
      rsp_err          <= 1'b0;
      op_count         <= '0;
    end else begin
      mul_op_start <= 1'b0;
      mul_op_clear <= 1'b0;
      rsp_valid    <= '0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            mul_multiplier   <= sel_multiplier;
            mul_multiplicand <= sel_multiplicand;
            gnt_id           <= grant_id;
            mul_op_start     <= 1'b1;
            state            <= S_START;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a watchdog expiring the same cycle.
          if (mul_op_done) begin
            rsp_result        <= mul_result;
            rsp_err           <= 1'b0;
            rsp_valid[gnt_id] <= 1'b1;
            op_count          <= op_count + 32'd1;
            mul_op_clear      <= 1'b1;
            state             <= S_CLEAR;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_result        <= '0;
            rsp_err           <= 1'b1;
            rsp_valid[gnt_id] <= 1'b1;
            mul_op_clear      <= 1'b1;
            state             <= S_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CLEAR: begin
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched
//   Directed bench for mul_sched (NREQ=4, TIMEOUT=16). A behavioural
//   multiplier with programmable latency answers start pulses; it re-arms
//   only on clear and can be switched into a never-completing stub.
module tb_mul_sched;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [255:0]  req_multiplier;
  logic [255:0]  req_multiplicand;
  logic [3:0]    rsp_valid;
  logic [127:0]  rsp_result;
  logic          rsp_err;
  logic          busy;
  logic [31:0]   op_count;
  logic          mul_op_start;
  logic          mul_op_clear;
  logic [63:0]   mul_multiplier;
  logic [63:0]   mul_multiplicand;
  logic          mul_op_done;
  logic [127:0]  mul_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mul_sched #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .rsp_valid        (rsp_valid),
    .rsp_result       (rsp_result),
    .rsp_err          (rsp_err),
    .busy             (busy),
    .op_count         (op_count),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: done appears lat cycles after the start cycle.
  logic         armed;
  logic         running;
  logic         stub;
  int           lat;
  int           k;
  logic [127:0] prod;

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x;
    logic signed [127:0] y;
    x = {{64{a[63]}}, a};
    y = {{64{b[63]}}, b};
    return x * y;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b1;
      running     <= 1'b0;
      k           <= 0;
      prod        <= '0;
      mul_op_done <= 1'b0;
      mul_result  <= '0;
    end else begin
      mul_op_done <= 1'b0;
      if (mul_op_clear) begin
        armed      <= 1'b1;
        running    <= 1'b0;
        mul_result <= '0;
      end else if (mul_op_start) begin
        if (armed && !stub) begin
          running <= 1'b1;
          k       <= 1;
          prod    <= smul(mul_multiplier, mul_multiplicand);
        end
        armed <= 1'b0;
      end else if (running) begin
        if (k == lat - 1) begin
          mul_op_done <= 1'b1;
          mul_result  <= prod;
          running     <= 1'b0;
        end else begin
          k <= k + 1;
        end
      end
    end
  end

  // Event log sampled mid-cycle.
  int           xfer_cyc[$];
  logic [3:0]   xfer_vec[$];
  int           start_cyc[$];
  logic [63:0]  start_a[$];
  logic [63:0]  start_b[$];
  int           rsp_cyc[$];
  logic [3:0]   rsp_vec[$];
  logic [127:0] rsp_res[$];
  logic         rsp_e[$];
  int           clr_cyc[$];
  int           ready_cycles = 0;
  int           bad_ready = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if ((req_valid & req_ready) != 4'd0) begin
        xfer_cyc.push_back(cyc);
        xfer_vec.push_back(req_ready);
      end
      if (req_ready != 4'd0) ready_cycles++;
      if (((req_ready & (req_ready - 4'd1)) != 4'd0) || (req_ready != 4'd0 && busy)) bad_ready++;
      if (mul_op_start) begin
        start_cyc.push_back(cyc);
        start_a.push_back(mul_multiplier);
        start_b.push_back(mul_multiplicand);
      end
      if (rsp_valid != 4'd0) begin
        rsp_cyc.push_back(cyc);
        rsp_vec.push_back(rsp_valid);
        rsp_res.push_back(rsp_result);
        rsp_e.push_back(rsp_err);
      end
      if (mul_op_clear) clr_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and wait for its transfer; t is the transfer cycle.
  task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b, output int t);
    bit got;
    got = 0;
    t   = 0;
    @(posedge clk); #2;
    req_multiplier[id*64 +: 64]   = a;
    req_multiplicand[id*64 +: 64] = b;
    req_valid[id]                 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        t   = cyc;
        got = 1;
        break;
      end
    end
    @(posedge clk); #2;
    req_valid[id] = 1'b0;
    if (!got) checkOutput("grant_wait", 128'd0, 128'd1);
  endtask

  // Hold several requesters valid until cnt transfers have happened.
  task automatic applyMulti(input logic [3:0] vec, input int cnt);
    int target;
    target = xfer_cyc.size() + cnt;
    @(posedge clk); #2;
    req_valid = vec;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (xfer_cyc.size() >= target) break;
    end
    @(posedge clk); #2;
    req_valid = 4'd0;
    checkOutput("multi_xfer_cnt", 128'(xfer_cyc.size() >= target), 128'd1);
  endtask

  task automatic waitRsp(input int target);
    for (int n = 0; n < 300; n++) begin
      if (rsp_cyc.size() >= target) break;
      @(negedge clk);
    end
    checkOutput("rsp_wait", 128'(rsp_cyc.size() >= target), 128'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    int bx, bs, br, bc, brdy;
    int exp_id[5];
    logic [127:0] exp_res[5];
    bit ok;

    reset_n          = 1'b0;
    req_valid        = 4'd0;
    req_multiplier   = '0;
    req_multiplicand = '0;
    stub             = 1'b0;
    lat              = 6;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 128'(req_ready), 128'd0);
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("rst_rsp_result", rsp_result, 128'd0);
    checkOutput("rst_rsp_err", 128'(rsp_err), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_op_count", 128'(op_count), 128'd0);
    checkOutput("rst_op_start", 128'(mul_op_start), 128'd0);
    checkOutput("rst_op_clear", 128'(mul_op_clear), 128'd0);
    checkOutput("rst_mul_a", 128'(mul_multiplier), 128'd0);
    checkOutput("rst_mul_b", 128'(mul_multiplicand), 128'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Idle for 50 cycles with no requests
    repeat (50) @(negedge clk);
    checkOutput("idle_starts", 128'(start_cyc.size()), 128'd0);
    checkOutput("idle_rsps", 128'(rsp_cyc.size()), 128'd0);
    checkOutput("idle_busy", 128'(busy), 128'd0);

    // Round robin, all four valid continuously: A=i+2, B=7
    for (int i = 0; i < 4; i++) begin
      req_multiplier[i*64 +: 64]   = 64'(i + 2);
      req_multiplicand[i*64 +: 64] = 64'd7;
    end
    exp_id  = '{0, 1, 2, 3, 0};
    exp_res = '{128'd14, 128'd21, 128'd28, 128'd35, 128'd14};
    bx = xfer_cyc.size(); bs = start_cyc.size(); br = rsp_cyc.size(); bc = clr_cyc.size();
    applyMulti(4'hF, 5);
    waitRsp(br + 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), 128'(xfer_vec[bx+i]), 128'(4'b0001 << exp_id[i]));
      checkOutput($sformatf("rr_rspvec%0d", i), 128'(rsp_vec[br+i]), 128'(4'b0001 << exp_id[i]));
      checkOutput($sformatf("rr_result%0d", i), rsp_res[br+i], exp_res[i]);
      checkOutput($sformatf("rr_err%0d", i), 128'(rsp_e[br+i]), 128'd0);
      checkOutput($sformatf("rr_start_cyc%0d", i), 128'(start_cyc[bs+i]), 128'(xfer_cyc[bx+i] + 1));
      checkOutput($sformatf("rr_clear_cyc%0d", i), 128'(clr_cyc[bc+i]), 128'(rsp_cyc[br+i]));
      if (i > 0)
        checkOutput($sformatf("rr_b2b_cyc%0d", i), 128'(xfer_cyc[bx+i]), 128'(rsp_cyc[br+i-1] + 1));
    end
    checkOutput("rr_op_count", 128'(op_count), 128'd5);

    // Single request: requester 1, A=-3, B=5
    bx = xfer_cyc.size(); bs = start_cyc.size(); br = rsp_cyc.size(); bc = clr_cyc.size();
    brdy = ready_cycles;
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, t);
    waitRsp(br + 1);
    repeat (5) @(negedge clk);
    checkOutput("single_ready_vec", 128'(xfer_vec[bx]), 128'(4'b0010));
    checkOutput("single_ready_cycles", 128'(ready_cycles - brdy), 128'd1);
    checkOutput("single_starts", 128'(start_cyc.size() - bs), 128'd1);
    checkOutput("single_start_cyc", 128'(start_cyc[bs]), 128'(t + 1));
    checkOutput("single_start_a", 128'(start_a[bs]), 128'(64'hFFFF_FFFF_FFFF_FFFD));
    checkOutput("single_start_b", 128'(start_b[bs]), 128'd5);
    checkOutput("single_rsp_cyc", 128'(rsp_cyc[br]), 128'(t + 8));
    checkOutput("single_rsp_vec", 128'(rsp_vec[br]), 128'(4'b0010));
    checkOutput("single_result", rsp_res[br], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    checkOutput("single_err", 128'(rsp_e[br]), 128'd0);
    checkOutput("single_clears", 128'(clr_cyc.size() - bc), 128'd1);
    checkOutput("single_clear_cyc", 128'(clr_cyc[bc]), 128'(t + 8));
    checkOutput("single_result_held", rsp_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    checkOutput("single_op_count", 128'(op_count), 128'd6);
    checkOutput("single_busy", 128'(busy), 128'd0);

    // Operand extremes
    br = rsp_cyc.size();
    applyStimulus(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, t);
    waitRsp(br + 1);
    checkOutput("max_pos_result", rsp_res[br], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
    br = rsp_cyc.size();
    applyStimulus(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, t);
    waitRsp(br + 1);
    checkOutput("min_neg_result", rsp_res[br], 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    checkOutput("min_neg_rspvec", 128'(rsp_vec[br]), 128'(4'b1000));

    // Done in the last WAIT cycle wins over the watchdog
    lat = 16;
    br = rsp_cyc.size();
    applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, t);
    waitRsp(br + 1);
    checkOutput("edge_rsp_cyc", 128'(rsp_cyc[br]), 128'(t + 18));
    checkOutput("edge_err", 128'(rsp_e[br]), 128'd0);
    checkOutput("edge_result", rsp_res[br], 128'd1);
    checkOutput("edge_op_count", 128'(op_count), 128'd9);

    // Timeout with a multiplier that never completes
    lat  = 6;
    stub = 1'b1;
    br = rsp_cyc.size(); bc = clr_cyc.size();
    applyStimulus(2, 64'd9, 64'd9, t);
    waitRsp(br + 1);
    checkOutput("to_rsp_cyc", 128'(rsp_cyc[br]), 128'(t + 18));
    checkOutput("to_rsp_vec", 128'(rsp_vec[br]), 128'(4'b0100));
    checkOutput("to_err", 128'(rsp_e[br]), 128'd1);
    checkOutput("to_result", rsp_res[br], 128'd0);
    checkOutput("to_clears", 128'(clr_cyc.size() - bc), 128'd1);
    ok = (clr_cyc[bc] == t + 18) || (clr_cyc[bc] == t + 19);
    checkOutput("to_clear_cyc", 128'(ok), 128'd1);
    checkOutput("to_op_count", 128'(op_count), 128'd9);
    checkOutput("to_busy", 128'(busy), 128'd0);
    stub = 1'b0;

    // Reset in the middle of WAIT abandons the operation
    lat = 14;
    applyStimulus(3, 64'd4, 64'd4, t);
    for (int n = 0; n < 50; n++) begin
      if (cyc >= t + 10) break;
      @(negedge clk);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 128'(busy), 128'd0);
    checkOutput("midrst_op_count", 128'(op_count), 128'd0);
    checkOutput("midrst_mul_a", 128'(mul_multiplier), 128'd0);
    checkOutput("midrst_rsp_result", rsp_result, 128'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    br = rsp_cyc.size();
    repeat (25) @(negedge clk);
    checkOutput("midrst_no_rsp", 128'(rsp_cyc.size() - br), 128'd0);

    // After reset rr_ptr is 0: with 1 and 3 valid, 1 wins first
    lat = 6;
    req_multiplier[1*64 +: 64]   = 64'd6;
    req_multiplicand[1*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFF9;
    req_multiplier[3*64 +: 64]   = 64'd4;
    req_multiplicand[3*64 +: 64] = 64'd4;
    bx = xfer_cyc.size(); br = rsp_cyc.size();
    applyMulti(4'b1010, 2);
    waitRsp(br + 2);
    checkOutput("post_rst_grant0", 128'(xfer_vec[bx]), 128'(4'b0010));
    checkOutput("post_rst_grant1", 128'(xfer_vec[bx+1]), 128'(4'b1000));
    checkOutput("post_rst_result0", rsp_res[br], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    checkOutput("post_rst_result1", rsp_res[br+1], 128'd16);
    checkOutput("post_rst_op_count", 128'(op_count), 128'd2);

    checkOutput("ready_onehot_idle", 128'(bad_ready), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
